expr_pipe_lanes: RTL and testbench

Parametrised, pipelined successor to the flat mixed-signedness expression blocks. It evaluates one of eight opcode-selected expressions on LANES independent lanes. Each lane pairs an unsigned operand with a signed one, and the result width is defined. Transactions enter and leave through valid/ready handshakes, and a bubble-collapsing pipeline STAGES deep sits between input and output. It serves as a registered, back-pressurable regression target for sign-extension, truncation and divide-by-zero semantics.

---
 rtl/expr_pipe_lanes.sv | 157 +++++++++++++++
 tb/tb_expr_pipe_lanes.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/expr_pipe_lanes.sv
// Multi-lane opcode-selected expression unit behind a bubble-collapsing valid/ready pipeline.
// Each lane pairs a zero-extended operand a with a sign-extended operand b and produces W result bits plus a flag.
module expr_pipe_lanes #(
  parameter int W      = 6,
  parameter int LANES  = 3,
  parameter int STAGES = 2,
  parameter int CW     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [LANES*W-1:0]   a,
  input  logic [LANES*W-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   y,
  output logic [LANES-1:0]     flag,
  output logic                 err,
  output logic [CW-1:0]        out_count
);

  localparam logic [W-1:0] W_VAL = W[W-1:0];

  // Returns {flag, y} for one lane.
  function automatic logic [W:0] lane_eval(input logic [2:0] opc,
                                           input logic [W-1:0] ua,
                                           input logic [W-1:0] sb);
    logic [W+1:0]        s;
    logic signed [2*W:0] p;
    logic [W-1:0]        r;
    logic                f;
    s = '0;
    p = '0;
    r = '0;
    f = 1'b0;
    case (opc)
      3'd0: begin
        s = {2'b00, ua} + {{2{sb[W-1]}}, sb};
        r = s[W-1:0];
        f = s[W+1] | s[W];
      end
      3'd1: begin
        s = {2'b00, ua} - {{2{sb[W-1]}}, sb};
        r = s[W-1:0];
        f = s[W+1] | s[W];
      end
      3'd2: begin
        if (ua >= W_VAL) begin
          r = {W{sb[W-1]}};
          f = 1'b1;
        end else begin
          r = $signed(sb) >>> ua;
        end
      end
      3'd3: begin
        r = {{(W-2){1'b0}}, (ua > sb), ($signed({1'b0, ua}) > $signed({sb[W-1], sb}))};
        f = (ua == sb);
      end
      3'd4: begin
        r = {{(W-4){1'b0}}, |sb, &ua, ~^sb, ^ua};
      end
      3'd5: begin
        p = $signed({{(W+1){1'b0}}, ua}) * $signed({{(W+1){sb[W-1]}}, sb});
        r = p[W-1:0];
        // In range only when the bits from W-1 upward are a pure sign extension.
        f = !((&p[2*W:W-1]) || !(|p[2*W:W-1]));
      end
      3'd6: begin
        if (sb == '0) begin
          r = '1;
          f = 1'b1;
        end else begin
          r = ua / sb;
        end
      end
      default: begin
        r = '0;
        f = 1'b0;
      end
    endcase
    return {f, r};
  endfunction

  logic [LANES*W-1:0] y_comb;
  logic [LANES-1:0]   flag_comb;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign {flag_comb[gi], y_comb[gi*W +: W]} = lane_eval(op, a[gi*W +: W], b[gi*W +: W]);
    end
  endgenerate

  logic [STAGES-1:0]  valid_reg;
  logic [LANES*W-1:0] y_reg    [STAGES];
  logic [LANES-1:0]   flag_reg [STAGES];
  logic [STAGES-1:0]  accept;
  logic               err_reg;
  logic [CW-1:0]      out_count_reg;

  // A stage can take new data if it or any later stage is empty, or the sink is draining.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_accept
      assign accept[gi] = out_ready | ~(&valid_reg[STAGES-1:gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        y_reg[k]     <= '0;
        flag_reg[k]  <= '0;
      end
    end else begin
      if (accept[0]) begin
        valid_reg[0] <= in_valid;
        if (in_valid) begin
          y_reg[0]    <= y_comb;
          flag_reg[0] <= flag_comb;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (accept[k]) begin
          valid_reg[k] <= valid_reg[k-1];
          if (valid_reg[k-1]) begin
            y_reg[k]    <= y_reg[k-1];
            flag_reg[k] <= flag_reg[k-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg       <= 1'b0;
      out_count_reg <= '0;
    end else begin
      if (in_valid && in_ready && (op == 3'd7)) begin
        err_reg <= 1'b1;
      end
      if (out_valid && out_ready) begin
        out_count_reg <= out_count_reg + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign in_ready  = accept[0];
  assign out_valid = valid_reg[STAGES-1];
  assign y         = y_reg[STAGES-1];
  assign flag      = flag_reg[STAGES-1];
  assign err       = err_reg;
  assign out_count = out_count_reg;

endmodule

// File: tb/tb_expr_pipe_lanes.sv
// Scoreboard bench for expr_pipe_lanes: stimulus pushes hand-computed results, a monitor pops on each output handshake.
// A second instance with CW=4 shares all inputs to exercise counter wrap.
module tb_expr_pipe_lanes;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  op = 3'd0;
  logic [17:0] a = '0;
  logic [17:0] b = '0;
  logic        in_ready, out_valid, err;
  logic [17:0] y;
  logic [2:0]  flag;
  logic [15:0] out_count;
  logic        in_ready4, out_valid4, err4;
  logic [17:0] y4;
  logic [2:0]  flag4;
  logic [3:0]  out_count4;

  expr_pipe_lanes #(.W(6), .LANES(3), .STAGES(2), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .flag(flag),
    .err(err), .out_count(out_count)
  );

  expr_pipe_lanes #(.W(6), .LANES(3), .STAGES(2), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .op(op),
    .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready), .y(y4), .flag(flag4),
    .err(err4), .out_count(out_count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] y;
    logic [2:0]  f;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_count = 0;

  function automatic logic [17:0] p3(input int x0, input int x1, input int x2);
    return {x2[5:0], x1[5:0], x0[5:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic send(input logic [2:0] o, input logic [17:0] av, input logic [17:0] bv,
                      input logic [17:0] ye, input logic [2:0] fe);
    int n;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = av;
    b = bv;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    e.y = ye;
    e.f = fe;
    q.push_back(e);
    $display("[TB] in  op=%0d a=%h b=%h", o, av, bv);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    exp_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: a handshake is committed at the next rising edge when both are high after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got y=%h flag=%b, expected no output", y, flag);
        end else begin
          e = q.pop_front();
          $display("[TB] out y=%h flag=%b exp_y=%h exp_flag=%b", y, flag, e.y, e.f);
          check("y", 32'(y), 32'(e.y));
          check("flag", 32'(flag), 32'(e.f));
          check("out_count", 32'(out_count), 32'(exp_count[15:0]));
        end
        exp_count++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_y", 32'(y), 0);
    check("rst_flag", 32'(flag), 0);
    check("rst_err", 32'(err), 0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    #11;
    rst_n = 1'b1;

    // ADD with latency check: captured into stage 0, visible at output one edge later.
    send(3'd0, p3(60, 60, 3), p3(-5, 10, -5), p3(55, 6, 62), 3'b110);
    check("lat_not_yet", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    check("lat_valid", 32'(out_valid), 1);
    drain();

    // ASR, MUL, DIV, SUB, CMP, RED
    send(3'd2, p3(2, 7, 0), p3(-32, -32, 17), p3(56, 63, 17), 3'b010);
    send(3'd5, p3(5, 20, 0), p3(-3, 3, 0), p3(49, 60, 0), 3'b010);
    send(3'd6, p3(50, 50, 50), p3(0, 7, -1), p3(63, 7, 0), 3'b001);
    send(3'd1, p3(10, 0, 63), p3(3, 1, -1), p3(7, 63, 0), 3'b110);
    send(3'd3, p3(40, 5, 7), p3(-1, 5, 3), p3(1, 0, 3), 3'b010);
    send(3'd4, p3(7, 63, 0), p3(0, -1, 1), p3(3, 14, 8), 3'b000);
    drain();

    // Illegal opcode followed by ADD; err sets on the op 7 handshake edge.
    check("err_before", 32'(err), 0);
    send(3'd7, p3(1, 2, 3), p3(4, 5, 6), p3(0, 0, 0), 3'b000);
    check("err_set", 32'(err), 1);
    send(3'd0, p3(1, 2, 3), p3(1, 1, 1), p3(2, 3, 4), 3'b000);
    drain();
    check("err_sticky", 32'(err), 1);

    // Reset with two items in flight: everything drops immediately, nothing stale afterwards.
    out_ready = 1'b0;
    send(3'd0, p3(9, 9, 9), p3(1, 1, 1), p3(10, 10, 10), 3'b000);
    send(3'd0, p3(8, 8, 8), p3(1, 1, 1), p3(9, 9, 9), 3'b000);
    check("inflight_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    q.delete();
    exp_count = 0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_err", 32'(err), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_out_count", 32'(out_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("no_stale", 32'(out_valid), 0);

    // Backpressure: 10 back-to-back items with out_ready low for 5 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(3'd0, p3(i, i + 10, i + 1), p3(1, 2, -1), p3(i + 1, i + 12, i), 3'b000);
        end
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("bp_in_ready_low", 32'(in_ready), 0);
        check("bp_out_valid_hold", 32'(out_valid), 1);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_out_count", 32'(out_count), 10);

    // Counter wrap on the CW=4 instance.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(3'd0, p3(i, 0, 0), p3(0, 0, 0), p3(i, 0, 0), 3'b000);
    end
    drain();
    check("wrap_count4", 32'(out_count4), 1);
    check("wrap_count16", 32'(out_count), 17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
